// File: rtl/dct4_transpose_buf_if.sv
// Row-in / column-out stream bundle for the 4x4 transpose buffer.
// The slave view belongs to the buffer; the master view belongs to its neighbours.
interface dct4_transpose_buf_if #(
  parameter int W = 33
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x0;
  logic [W-1:0] in_x1;
  logic [W-1:0] in_x2;
  logic [W-1:0] in_x3;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [W-1:0] out_y0;
  logic [W-1:0] out_y1;
  logic [W-1:0] out_y2;
  logic [W-1:0] out_y3;

  modport master (
    output in_valid,
    output in_x0,
    output in_x1,
    output in_x2,
    output in_x3,
    input  in_ready,
    input  out_valid,
    input  out_last,
    input  out_y0,
    input  out_y1,
    input  out_y2,
    input  out_y3,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_x0,
    input  in_x1,
    input  in_x2,
    input  in_x3,
    output in_ready,
    output out_valid,
    output out_last,
    output out_y0,
    output out_y1,
    output out_y2,
    output out_y3,
    input  out_ready
  );
endinterface

// File: rtl/dct4_transpose_buf.sv
// Double-buffered 4x4 transpose between row and column DCT passes.
// Rows fill one bank while the other bank drains as columns.
module dct4_transpose_buf #(
  parameter int W = 33
) (
  input logic clk,
  input logic rst,
  dct4_transpose_buf_if.slave bus
);

  typedef logic [W-1:0] word_t;

  word_t      bank_q [2][4][4];
  word_t      bank_d [2][4][4];
  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       wr_bank_q;
  logic       wr_bank_d;
  logic [1:0] wr_row_q;
  logic [1:0] wr_row_d;
  logic       rd_bank_q;
  logic       rd_bank_d;
  logic [1:0] rd_col_q;
  logic [1:0] rd_col_d;

  word_t row_in [4];
  logic  wr_fire;
  logic  rd_fire;

  assign row_in[0] = bus.in_x0;
  assign row_in[1] = bus.in_x1;
  assign row_in[2] = bus.in_x2;
  assign row_in[3] = bus.in_x3;

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_last  = full_q[rd_bank_q]
                      && (rd_col_q == 2'd3);

  assign bus.out_y0 = bank_q[rd_bank_q][0][rd_col_q];
  assign bus.out_y1 = bank_q[rd_bank_q][1][rd_col_q];
  assign bus.out_y2 = bank_q[rd_bank_q][2][rd_col_q];
  assign bus.out_y3 = bank_q[rd_bank_q][3][rd_col_q];

  assign wr_fire = bus.in_valid && !full_q[wr_bank_q];
  assign rd_fire = bus.out_ready && full_q[rd_bank_q];

  // Write and read never touch the same bank: one needs !full, the other full.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;

    if (wr_fire) begin
      for (int c = 0; c < 4; c++) begin
        bank_d[wr_bank_q][wr_row_q][c] = row_in[c];
      end
      wr_row_d = wr_row_q + 2'd1;
      if (wr_row_q == 2'd3) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (rd_fire) begin
      rd_col_d = rd_col_q + 2'd1;
      if (rd_col_q == 2'd3) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            bank_q[b][r][c] <= '0;
          end
        end
      end
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      bank_q    <= bank_d;
    end
  end

endmodule

// File: tb/tb_dct4_transpose_buf.sv
// Directed bench for the 4x4 transpose buffer.
// A column queue built from accepted rows checks every consumed beat.
module tb_dct4_transpose_buf;

  localparam int W = 33;
  typedef logic [W-1:0]   word_t;
  typedef logic [4*W-1:0] col_t;

  logic clk;
  logic rst;

  dct4_transpose_buf_if #(.W(W)) bus ();

  dct4_transpose_buf #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp;
  int    n_err;
  int    cyc;
  int    row_cnt;
  int    beat;
  int    acc_cnt;
  int    out_cnt;
  int    stall_cnt;
  int    blk_cyc;
  int    first_out;
  int    last_out;
  word_t rb [4][4];
  word_t blk_in [4][4];
  col_t  exp_q [$];

  task automatic chk(input string tag, input col_t got,
                     input col_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic word_t di(input int r, input int c);
    return {1'b0, 8'(8'h80 + r), 24'(24'hA00000 + c)};
  endfunction

  function automatic word_t d6(input int r, input int c);
    return {1'b1, 8'(8'h40 + r), 24'(24'h000100 + c)};
  endfunction

  function automatic col_t ycol();
    return {bus.out_y3, bus.out_y2, bus.out_y1, bus.out_y0};
  endfunction

  // One clock: observe mid-cycle, then advance to just after the edge.
  task automatic cycle();
    col_t col;
    @(negedge clk);
    if (bus.in_valid && !bus.in_ready) stall_cnt++;
    if (bus.in_valid && bus.in_ready) begin
      rb[row_cnt][0] = bus.in_x0;
      rb[row_cnt][1] = bus.in_x1;
      rb[row_cnt][2] = bus.in_x2;
      rb[row_cnt][3] = bus.in_x3;
      acc_cnt++;
      if (row_cnt == 3) begin
        blk_cyc = cyc;
        for (int c = 0; c < 4; c++) begin
          exp_q.push_back({rb[3][c], rb[2][c], rb[1][c], rb[0][c]});
        end
      end
      row_cnt = (row_cnt + 1) % 4;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        col = exp_q.pop_front();
        chk("sb_col", ycol(), col);
        chk("sb_last", bus.out_last, (beat % 4) == 3);
      end
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
      beat++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    row_cnt = 0;
    beat    = 0;
  endtask

  task automatic set_row(input int r);
    bus.in_x0 = blk_in[r][0];
    bus.in_x1 = blk_in[r][1];
    bus.in_x2 = blk_in[r][2];
    bus.in_x3 = blk_in[r][3];
  endtask

  task automatic feed_blk(input string tag);
    for (int r = 0; r < 4; r++) begin
      bus.in_valid = 1'b1;
      set_row(r);
      chk(tag, bus.in_ready, 1);
      cycle();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_int_blk();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk_in[r][c] = di(r, c);
  endtask

  int    rdy [12];
  int    shown [6];
  logic  pat [6];
  word_t f [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    row_cnt = 0; beat = 0; acc_cnt = 0;
    out_cnt = 0; stall_cnt = 0;
    blk_cyc = 0; first_out = 0; last_out = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_x0 = '0; bus.in_x1 = '0;
    bus.in_x2 = '0; bus.in_x3 = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    cycle();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_y", ycol(), '0);

    // Single block, integer encodings
    load_int_blk();
    bus.out_ready = 1'b1;
    out_cnt = 0;
    feed_blk("t2_rdy");
    chk("t2_valid", bus.out_valid, 1);
    for (int c = 0; c < 4; c++) begin
      chk("t2_col", ycol(), {di(3, c), di(2, c), di(1, c), di(0, c)});
      chk("t2_last", bus.out_last, c == 3);
      cycle();
    end
    chk("t2_latency", first_out - blk_cyc, 1);
    chk("t2_empty", bus.out_valid, 0);

    // Float values through lane 0
    f[0] = {1'b0, 8'h80, 24'hA00000};
    f[1] = {1'b1, 8'h81, 24'h800000};
    f[2] = {1'b0, 8'h81, 24'hB33333};
    f[3] = {1'b0, 8'h81, 24'hE00000};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk_in[r][c] = (r == 0) ? f[c] : '0;
    feed_blk("t3_rdy");
    for (int c = 0; c < 4; c++) begin
      chk("t3_y0", bus.out_y0, f[c]);
      chk("t3_y123", {bus.out_y3, bus.out_y2, bus.out_y1}, '0);
      cycle();
    end

    // Streaming: 5 back-to-back blocks
    out_cnt = 0; stall_cnt = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x0 = {1'b0, 8'(i), 24'(16 * 0 + i / 4)};
      bus.in_x1 = {1'b0, 8'(i), 24'(16 * 1 + i / 4)};
      bus.in_x2 = {1'b0, 8'(i), 24'(16 * 2 + i / 4)};
      bus.in_x3 = {1'b0, 8'(i), 24'(16 * 3 + i / 4)};
      cycle();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 40 && out_cnt < 20; k++) cycle();
    chk("t4_stalls", stall_cnt, 0);
    chk("t4_out_cnt", out_cnt, 20);
    chk("t4_consec", last_out - first_out, 19);

    // Backpressure
    acc_cnt = 0; out_cnt = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x0 = {1'b0, 8'h20, 24'(i * 4 + 0)};
      bus.in_x1 = {1'b0, 8'h20, 24'(i * 4 + 1)};
      bus.in_x2 = {1'b0, 8'h20, 24'(i * 4 + 2)};
      bus.in_x3 = {1'b0, 8'h20, 24'(i * 4 + 3)};
      rdy[i] = int'(bus.in_ready);
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("t5_accepted", acc_cnt, 8);
    chk("t5_rdy_c8", rdy[7], 1);
    chk("t5_rdy_c9", rdy[8], 0);
    chk("t5_rdy_c12", rdy[11], 0);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 3) begin
        chk("t5_last", bus.out_last, 1);
        chk("t5_rdy_at_last", bus.in_ready, 0);
      end
      if (j == 4) chk("t5_rdy_after", bus.in_ready, 1);
      cycle();
    end
    chk("t5_drained", out_cnt, 8);

    // Stall stability
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk_in[r][c] = d6(r, c);
    bus.out_ready = 1'b0;
    feed_blk("t6_rdy");
    out_cnt = 0;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    shown = '{0, 1, 1, 1, 2, 3};
    for (int k = 0; k < 6; k++) begin
      bus.out_ready = pat[k];
      chk("t6_valid", bus.out_valid, 1);
      chk("t6_y1", bus.out_y1, d6(1, shown[k]));
      chk("t6_y3", bus.out_y3, d6(3, shown[k]));
      chk("t6_last", bus.out_last, shown[k] == 3);
      cycle();
    end
    chk("t6_beats", out_cnt, 4);
    chk("t6_empty", bus.out_valid, 0);

    // Reset with one full block and a partial one
    load_int_blk();
    bus.out_ready = 1'b0;
    feed_blk("t7_rdy_a");
    for (int r = 0; r < 2; r++) begin
      bus.in_valid = 1'b1;
      bus.in_x0 = 33'h1_2345_6789;
      bus.in_x1 = 33'h0_DEAD_BEEF;
      bus.in_x2 = 33'h1_0000_0001;
      bus.in_x3 = 33'h0_FFFF_FFFF;
      cycle();
    end
    do_reset();
    chk("t7_valid", bus.out_valid, 0);
    chk("t7_in_ready", bus.in_ready, 1);
    chk("t7_last", bus.out_last, 0);
    chk("t7_y", ycol(), '0);
    out_cnt = 0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    chk("t7_no_stale", out_cnt, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk_in[r][c] = di(3 - r, c);
    feed_blk("t7_rdy_b");
    for (int c = 0; c < 4; c++) begin
      chk("t7_col", ycol(), {di(0, c), di(1, c), di(2, c), di(3, c)});
      cycle();
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
